// File: rtl/flash_arb.sv
// Two-port round-robin arbiter in front of the flash reader.
// One read in flight at a time, with a WAIT-state timeout.
module flash_arb #(
  parameter int TIMEOUT = 1024,
  parameter int AW      = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_stb,
  input  logic [AW-1:0] m0_addr,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic          m1_stb,
  input  logic [AW-1:0] m1_addr,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [31:0]   rdata,
  output logic          rom_stb,
  output logic [AW-1:0] rom_addr,
  input  logic          rom_ack,
  input  logic [31:0]   rom_odata,
  output logic          busy,
  output logic          owner
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           pend_q, pend_d;
  logic [1:0][AW-1:0]   addr_q, addr_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic [AW-1:0]        rom_addr_q, rom_addr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [1:0]           ack_q, ack_d;
  logic [1:0]           err_q, err_d;
  logic [1:0]           clr;
  logic [1:0]           stb;
  logic [1:0][AW-1:0]   maddr;
  logic                 grant;

  assign stb      = {m1_stb, m0_stb};
  assign maddr[0] = m0_addr;
  assign maddr[1] = m1_addr;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    addr_d     = addr_q;
    owner_d    = owner_q;
    last_d     = last_q;
    rom_addr_d = rom_addr_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    ack_d      = '0;
    err_d      = '0;
    clr        = '0;
    grant      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          // on a tie the port that was not served last wins
          grant      = (&pend_q) ? ~last_q : pend_q[1];
          owner_d    = grant;
          rom_addr_d = addr_q[grant];
          cnt_d      = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (rom_ack) begin
          rdata_d         = rom_odata;
          ack_d[owner_q]  = 1'b1;
          state_d         = S_DONE;
        end else if (state_q == S_ISSUE) begin
          state_d = S_WAIT;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d[owner_q] = 1'b1;
          clr[owner_q]   = 1'b1;
          last_d         = owner_q;
          state_d        = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        clr[owner_q] = 1'b1;
        last_d       = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // a new strobe beats a same-cycle clear
    for (int i = 0; i < 2; i++) begin
      if (stb[i] && (!pend_q[i] || clr[i]))
        addr_d[i] = maddr[i];
      pend_d[i] = (pend_q[i] & ~clr[i]) | stb[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      addr_q     <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      rom_addr_q <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      ack_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      addr_q     <= addr_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      rom_addr_q <= rom_addr_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_err   = err_q[0];
  assign m1_err   = err_q[1];
  assign rdata    = rdata_q;
  assign rom_addr = rom_addr_q;
  assign rom_stb  = (state_q == S_ISSUE);
  assign busy     = (state_q != S_IDLE);
  assign owner    = owner_q;

endmodule
